// File: rtl/alu_shift_multi.sv
// alu_shift_multi
//   Multi-cycle shift/rotate unit for the ALU shift path. It accepts one of
//   twelve shift/rotate opcodes and a shift amount. It then performs one
//   single-bit step per clock and carries the running carry from step to step.
//   The result and flags are registered and stay put for writeback.
//
//   Opcode map:
//     0x80 SHR0   0x81 SHR1   0x82 SHRA   0x83 SHRC   0x84 ROTR   0x85 ROTRC
//     0x88 SHL0   0x89 SHL1   0x8A SHLA   0x8B SHLC   0x8C ROTL   0x8D ROTLC
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start                 request, accepted in IDLE or DONE
//   op_in                 opcode, latched on accept
//   a_in                  shift amount in bits [amt_wl-1:0]; the rest is ignored
//   b_in                  operand to shift, latched on accept
//   z/s/c/ovr_flag_in     incoming flags, latched on accept
//   c_out                 registered result
//   z/s/c/ovr_flag_out    registered flags
//   op_active             holding the result of a valid shift opcode
//   busy                  high while stepping
//   done                  one-cycle pulse when the result is valid
module alu_shift_multi #(
    parameter int data_wl = 16,
    parameter int op_wl   = 8,
    parameter int amt_wl  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [op_wl-1:0]   op_in,
    input  logic [data_wl-1:0] a_in,
    input  logic [data_wl-1:0] b_in,
    input  logic               z_flag_in,
    input  logic               s_flag_in,
    input  logic               c_flag_in,
    input  logic               ovr_flag_in,
    output logic [data_wl-1:0] c_out,
    output logic               z_flag_out,
    output logic               s_flag_out,
    output logic               c_flag_out,
    output logic               ovr_flag_out,
    output logic               op_active,
    output logic               busy,
    output logic               done
);

    localparam logic [op_wl-1:0] OP_SHR0  = op_wl'(8'h80);
    localparam logic [op_wl-1:0] OP_SHR1  = op_wl'(8'h81);
    localparam logic [op_wl-1:0] OP_SHRA  = op_wl'(8'h82);
    localparam logic [op_wl-1:0] OP_SHRC  = op_wl'(8'h83);
    localparam logic [op_wl-1:0] OP_ROTR  = op_wl'(8'h84);
    localparam logic [op_wl-1:0] OP_ROTRC = op_wl'(8'h85);
    localparam logic [op_wl-1:0] OP_SHL0  = op_wl'(8'h88);
    localparam logic [op_wl-1:0] OP_SHL1  = op_wl'(8'h89);
    localparam logic [op_wl-1:0] OP_SHLA  = op_wl'(8'h8A);
    localparam logic [op_wl-1:0] OP_SHLC  = op_wl'(8'h8B);
    localparam logic [op_wl-1:0] OP_ROTL  = op_wl'(8'h8C);
    localparam logic [op_wl-1:0] OP_ROTLC = op_wl'(8'h8D);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic op_valid(input logic [op_wl-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_SHR0, OP_SHR1, OP_SHRA, OP_SHRC, OP_ROTR, OP_ROTRC,
            OP_SHL0, OP_SHL1, OP_SHLA, OP_SHLC, OP_ROTL, OP_ROTLC: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // One single-bit step. Returns {new_carry, new_value}. Only the
    // through-carry rotates replace the carry.
    function automatic logic [data_wl:0] shift_step(
        input logic [op_wl-1:0]   op,
        input logic [data_wl-1:0] v,
        input logic               c
    );
        logic [data_wl-1:0] nv;
        logic               nc;
        nv = v;
        nc = c;
        case (op)
            OP_SHR0:  nv = {1'b0, v[data_wl-1:1]};
            OP_SHR1:  nv = {1'b1, v[data_wl-1:1]};
            OP_SHRA:  nv = {v[data_wl-1], v[data_wl-1:1]};
            OP_SHRC:  nv = {c, v[data_wl-1:1]};
            OP_ROTR:  nv = {v[0], v[data_wl-1:1]};
            OP_ROTRC: begin
                nv = {c, v[data_wl-1:1]};
                nc = v[0];
            end
            OP_SHL0:  nv = {v[data_wl-2:0], 1'b0};
            OP_SHL1:  nv = {v[data_wl-2:0], 1'b1};
            OP_SHLA:  nv = {v[data_wl-2:0], v[0]};
            OP_SHLC:  nv = {v[data_wl-2:0], c};
            OP_ROTL:  nv = {v[data_wl-2:0], v[data_wl-1]};
            OP_ROTLC: begin
                nv = {v[data_wl-2:0], c};
                nc = v[data_wl-1];
            end
            default:  nv = v;
        endcase
        return {nc, nv};
    endfunction

    state_t             state, state_next;
    logic               accept;
    logic               in_valid;
    logic [amt_wl-1:0]  amt_in;
    logic               unused_a_bits;

    logic [data_wl-1:0] v_p1;
    logic               c_p1;
    logic [amt_wl-1:0]  cnt_p1;
    logic [op_wl-1:0]   op_p1;
    logic               ovr_p1;

    logic [data_wl:0]   step_res;
    logic               last_step;
    logic               load_out;
    logic [data_wl-1:0] res_v;
    logic               res_c;
    logic               res_ovr;

    assign amt_in        = a_in[amt_wl-1:0];
    assign unused_a_bits = ^a_in[data_wl-1:amt_wl];
    assign in_valid      = op_valid(op_in);
    assign step_res      = shift_step(op_p1, v_p1, c_p1);
    assign last_step     = (state == SHIFT) && (cnt_p1 == amt_wl'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE accepts a new request directly, so back-to-back operations do not
    // pass through IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE:  accept = start;
            SHIFT: if (cnt_p1 == amt_wl'(1)) state_next = DONE;
            DONE: begin
                state_next = IDLE;
                accept     = start;
            end
            default: state_next = IDLE;
        endcase
        if (accept) begin
            state_next = (in_valid && (amt_in != '0)) ? SHIFT : DONE;
        end
    end

    // The result comes from one of two places. On accept, an invalid opcode
    // or a zero amount completes immediately from the inputs. Otherwise the
    // result is the output of the last step.
    always_comb begin
        load_out = 1'b0;
        res_v    = step_res[data_wl-1:0];
        res_c    = step_res[data_wl];
        res_ovr  = ovr_p1;
        if (accept) begin
            load_out = !in_valid || (amt_in == '0);
            res_v    = in_valid ? b_in : '0;
            res_c    = in_valid ? c_flag_in : 1'b0;
            res_ovr  = ovr_flag_in;
        end else if (last_step) begin
            load_out = 1'b1;
        end
    end

    // Stage p1: working value, running carry and step counter.
    always_ff @(posedge clk) begin
        if (accept) begin
            v_p1   <= b_in;
            c_p1   <= c_flag_in;
            cnt_p1 <= amt_in;
            op_p1  <= op_in;
            ovr_p1 <= ovr_flag_in;
        end else if (state == SHIFT) begin
            {c_p1, v_p1} <= step_res;
            cnt_p1       <= cnt_p1 - amt_wl'(1);
        end
    end

    // Stage p2: registered results, held until the next DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_out        <= '0;
            z_flag_out   <= 1'b0;
            s_flag_out   <= 1'b0;
            c_flag_out   <= 1'b0;
            ovr_flag_out <= 1'b0;
            op_active    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= load_out;
            busy <= (state_next == SHIFT);
            if (accept) begin
                op_active <= in_valid;
            end
            if (load_out) begin
                c_out        <= res_v;
                z_flag_out   <= (res_v == '0);
                s_flag_out   <= res_v[data_wl-1];
                c_flag_out   <= res_c;
                ovr_flag_out <= res_ovr;
            end
        end
    end

endmodule

// File: doc/alu_shift_multi.md
Name: alu_shift_multi

Overview:
- Sequential multi-bit successor to the single-step shifter in the ALU shift path.
- Takes one of the 12 shift/rotate opcodes (0x80-0x8D) plus a shift amount.
- Executes one single-bit step per clock, carrying the running carry between steps.
- Uses a start/busy/done handshake; results and flags are registered and held for the ALU writeback stage.

Parameters:
- data_wl, 16, operand/result width (>= 2).
- op_wl, 8, opcode width.
- amt_wl, 4, shift-amount width; amounts range 0 .. 2^amt_wl-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  request; sampled only when not busy.
- op_in  in  op_wl  opcode, latched on accept.
- a_in  in  data_wl  shift amount source; bits [amt_wl-1:0] are latched, the rest are ignored.
- b_in  in  data_wl  operand to shift, latched on accept.
- z_flag_in, s_flag_in, c_flag_in, ovr_flag_in  in  1 each  incoming flags, latched on accept.
- c_out  out  data_wl  registered result.
- z_flag_out, s_flag_out, c_flag_out, ovr_flag_out  out  1 each  registered flags.
- op_active  out  1  high while holding the result of a valid shift opcode.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse: result valid.

Behaviour:
- One clock domain. Reset is synchronous and active-low; clock port clk, reset port rst_n.
- Reset (rst_n low at a rising edge):
  - state goes to IDLE.
  - c_out, all four flag outputs, op_active, busy and done go to 0.
  - Reset wins over start and aborts any operation in flight; no done is produced for it.
- States: IDLE, SHIFT, DONE.
- Accept: start high at an edge while in IDLE or DONE (back-to-back allowed).
  - Latches b_in into the working register, N = a_in[amt_wl-1:0], op_in, and the four flags.
  - Sets op_active = 1 if the opcode is valid.
  - start while in SHIFT is ignored; it is not queued.
- Invalid opcode (anything other than 0x80-0x85, 0x88-0x8D):
  - Go straight to DONE.
  - Result = 0, c_flag_out = 0, z = 1, s = 0, op_active = 0, ovr = latched ovr_flag_in.
- Valid opcode, N = 0: go to DONE; result = latched b_in, c_flag_out = latched c_flag_in.
- Valid opcode, N > 0: go to SHIFT. Each edge in SHIFT performs one step on the working value V with running carry C, then decrements the counter. After the Nth step, go to DONE.
- Step definitions, right shifts (V >> 1, MSB filled):
  - SHR0: MSB = 0.
  - SHR1: MSB = 1.
  - SHRA: MSB = V[msb].
  - SHRC: MSB = C, C unchanged.
  - ROTR: MSB = V[0].
  - ROTRC: MSB = C, then C = old V[0].
- Step definitions, left shifts (V << 1, LSB filled):
  - SHL0: LSB = 0.
  - SHL1: LSB = 1.
  - SHLA: LSB = V[0].
  - SHLC: LSB = C, C unchanged.
  - ROTL: LSB = V[msb].
  - ROTLC: LSB = C, then C = old V[msb].
- For every op except ROTRC and ROTLC, C stays equal to the latched c_flag_in.
- DONE lasts exactly one cycle with done = 1.
  - Next state is IDLE, or a fresh accept if start is high.
- Latency: with start sampled in cycle 0, done is high in cycle N+1.
- Output registers:
  - c_out = V and c_flag_out = C.
  - z_flag_out = (V == 0), s_flag_out = V[msb], ovr_flag_out = latched ovr_flag_in.
  - All are updated on entry to DONE and held stable until the next DONE or reset.
  - c_out and the flags do not change during SHIFT.
- busy = (state == SHIFT); it is low in IDLE and DONE.

Test Plan (data_wl = 16):
1. SHR0, b = 0x8001, amount 3, c_in = 1 → c_out = 0x1000, z = 0, s = 0, c = 1, op_active = 1; done in cycle 4; busy high in cycles 1-3.
2. ROTRC, b = 0x0003, amount 2, c_in = 0 → c_out = 0x8000, c = 1, s = 1, z = 0; done in cycle 3.
3. SHRA, b = 0x8000, amount 15 → c_out = 0xFFFF, s = 1; done in cycle 16. Immediately follow with SHL1, b = 0x1234, amount 0, start held high during DONE → c_out = 0x1234, done one cycle after the first done.
4. Opcode 0x00 with b = 0xFFFF, c_in = 1, ovr_in = 1 → c_out = 0, z = 1, c = 0, ovr = 1, op_active = 0; done in cycle 1.
5. ROTL, b = 0x8001, amount 10; pulse start again in cycle 3 and drive rst_n low in cycle 5 → second start ignored; after the reset edge all outputs = 0, state IDLE, no done pulse at any point.
6. ROTLC, b = 0x8000, amount 1, c_in = 0 → c_out = 0x0000, c = 1, z = 1, s = 0.
